// File: rtl/phase_seq_pkg.sv
// Shared types for the three-phase sequencer.
// State encoding and the idle phase index.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] IDX_IDLE = 2'd3;

  // One-hot phase enable for a phase state, zero elsewhere.
  function automatic logic [2:0] phase_onehot(state_t s);
    logic [2:0] r;
    r = 3'b000;
    unique case (s)
      P0:      r = 3'b001;
      P1:      r = 3'b010;
      P2:      r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_seq_if.sv
// Control/status bundle between the control FSM
// and the phase sequencer.
interface phase_seq_if #(
  parameter int CW = 8,
  parameter int RW = 4
);

  logic          start;
  logic          abort;
  logic          hold;
  logic [CW-1:0] len0;
  logic [CW-1:0] len1;
  logic [CW-1:0] len2;
  logic [RW-1:0] reps;
  logic          busy;
  logic [2:0]    phase_en;
  logic [1:0]    phase_idx;
  logic          done;
  logic          err;

  modport master (
    output start, abort, hold,
    output len0, len1, len2, reps,
    input  busy, phase_en, phase_idx,
    input  done, err
  );

  modport slave (
    input  start, abort, hold,
    input  len0, len1, len2, reps,
    output busy, phase_en, phase_idx,
    output done, err
  );

endinterface

// File: rtl/phase_seq_dwell_counter.sv
// Down-counter timing the dwell of one phase.
// Load wins over enable; the count never wraps.
module dwell_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload, decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Sequences a datapath through P0->P1->P2 with
// per-phase dwell, repeat count, hold and abort.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int CW = 8,
  parameter int RW = 4
) (
  input  logic        clk,
  input  logic        reset,
  phase_seq_if.slave  bus
);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] len0_q, len0_d;
  logic [CW-1:0] len1_q, len1_d;
  logic [CW-1:0] len2_q, len2_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          cfg_ok;

  assign cfg_ok = (bus.reps != '0) && (bus.len0 != '0) &&
                  (bus.len1 != '0) && (bus.len2 != '0);

  dwell_counter #(.CW(CW)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and latched config.
  always_comb begin
    state_d  = state_q;
    len0_d   = len0_q;
    len1_d   = len1_q;
    len2_d   = len2_q;
    rep_d    = rep_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            len0_d   = bus.len0;
            len1_d   = bus.len1;
            len2_d   = bus.len2;
            rep_d    = bus.reps;
            cnt_load = 1'b1;
            cnt_val  = bus.len0 - C_ONE;
            state_d  = P0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      P0: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = len1_q - C_ONE;
            state_d  = P1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      P1: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = len2_q - C_ONE;
            state_d  = P2;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      P2: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (rep_q > R_ONE) begin
            rep_d    = rep_q - R_ONE;
            cnt_load = 1'b1;
            cnt_val  = len0_q - C_ONE;
            state_d  = P0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State, config and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len0_q  <= '0;
      len1_q  <= '0;
      len2_q  <= '0;
      rep_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len0_q  <= len0_d;
      len1_q  <= len1_d;
      len2_q  <= len2_d;
      rep_q   <= rep_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Output decode from registered state and hold.
  always_comb begin
    bus.busy      = 1'b0;
    bus.phase_idx = IDX_IDLE;
    unique case (state_q)
      P0: begin
        bus.busy      = 1'b1;
        bus.phase_idx = 2'd0;
      end
      P1: begin
        bus.busy      = 1'b1;
        bus.phase_idx = 2'd1;
      end
      P2: begin
        bus.busy      = 1'b1;
        bus.phase_idx = 2'd2;
      end
      default: begin
        bus.busy      = 1'b0;
        bus.phase_idx = IDX_IDLE;
      end
    endcase
    bus.phase_en = bus.hold ? 3'b000 : phase_onehot(state_q);
    bus.done     = done_q;
    bus.err      = err_q;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer.
// Drives and samples 1ns after each rising edge.
module tb_phase_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  phase_seq_if #(.CW(8), .RW(4)) bus ();

  phase_sequencer #(.CW(8), .RW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_en"}, 32'(bus.phase_en), 0);
    chk({tag, "_idx"}, 32'(bus.phase_idx), 3);
  endtask

  task automatic setcfg(input int l0, input int l1,
                        input int l2, input int r);
    bus.len0 = 8'(l0);
    bus.len1 = 8'(l1);
    bus.len2 = 8'(l2);
    bus.reps = 4'(r);
  endtask

  // Start a run and follow it cycle by cycle.
  task automatic run_pass(input string tag, input int l0,
                          input int l1, input int l2,
                          input int r);
    int lens[3];
    int n;
    logic [2:0] e;
    lens[0] = l0;
    lens[1] = l1;
    lens[2] = l2;
    n = 0;
    setcfg(l0, l1, l2, r);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < r; p++) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < lens[k]; c++) begin
          e = 3'b001 << k;
          chk({tag, "_en"}, 32'(bus.phase_en), 32'(e));
          chk({tag, "_idx"}, 32'(bus.phase_idx), k);
          chk({tag, "_busy"}, 32'(bus.busy), 1);
          chk({tag, "_nodone"}, 32'(bus.done), 0);
          tick();
          n++;
        end
      end
    end
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk_idle({tag, "_dn"});
    tick();
    chk({tag, "_done1"}, 32'(bus.done), 0);
    chk_idle({tag, "_post"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    setcfg(2, 2, 2, 1);

    // Reset wins even with a valid start present.
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    chk_idle("rst_rel");

    // Basic run.
    run_pass("basic", 2, 3, 1, 1);

    // Three repeats of unit dwells: done on 10th cycle.
    run_pass("reps", 1, 1, 1, 3);

    // Hold during P0 stretches it to 7 cycles.
    setcfg(4, 1, 1, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("hold_pre", 32'(bus.phase_en), 1);
      tick();
    end
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_en", 32'(bus.phase_en), 0);
      chk("hold_busy", 32'(bus.busy), 1);
      chk("hold_idx", 32'(bus.phase_idx), 0);
      tick();
    end
    bus.hold = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("hold_post", 32'(bus.phase_en), 1);
      tick();
    end
    chk("hold_p1", 32'(bus.phase_en), 3'b010);
    tick();
    chk("hold_p2", 32'(bus.phase_en), 3'b100);
    tick();
    chk("hold_done", 32'(bus.done), 1);
    tick();

    // Abort in 2nd cycle of P1.
    setcfg(2, 3, 2, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_idx", 32'(bus.phase_idx), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("abort");
    for (int c = 0; c < 6; c++) begin
      chk("abort_nodone", 32'(bus.done), 0);
      tick();
    end
    run_pass("after_abort", 2, 1, 1, 1);

    // Rejected starts.
    setcfg(1, 1, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rej0_err", 32'(bus.err), 1);
    chk_idle("rej0");
    tick();
    chk("rej0_err1", 32'(bus.err), 0);
    chk_idle("rej0b");
    setcfg(1, 0, 1, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rej1_err", 32'(bus.err), 1);
    chk_idle("rej1");
    tick();
    chk("rej1_err1", 32'(bus.err), 0);

    // Reset during P2.
    setcfg(1, 1, 3, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("rstmid_idx", 32'(bus.phase_idx), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rstmid");
    chk("rstmid_done", 32'(bus.done), 0);
    chk("rstmid_err", 32'(bus.err), 0);
    tick();
    chk("rstmid_done1", 32'(bus.done), 0);

    // Start during P1 is ignored; run completes unchanged.
    setcfg(2, 3, 1, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("busy_start_idx", 32'(bus.phase_idx), 1);
    bus.start = 1'b1;
    setcfg(5, 5, 5, 2);
    for (int c = 0; c < 3; c++) begin
      chk("busy_start_p1", 32'(bus.phase_en), 3'b010);
      tick();
    end
    bus.start = 1'b0;
    chk("busy_start_p2", 32'(bus.phase_en), 3'b100);
    chk("busy_start_err", 32'(bus.err), 0);
    tick();
    chk("busy_start_done", 32'(bus.done), 1);
    tick();
    chk_idle("busy_start_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
